player_executor: RTL and testbench



---
 rtl/player_executor.sv | 150 +++++++++++++++
 tb/tb_player_executor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/player_executor.sv
// Player soul executor: decodes FSM player instructions and keeps the
// soul's arena position, HP, liveness and invulnerability window.
module player_executor #(
  parameter logic [7:0]  X_MIN      = 8'd20,
  parameter logic [7:0]  X_MAX      = 8'd220,
  parameter logic [7:0]  Y_MIN      = 8'd20,
  parameter logic [7:0]  Y_MAX      = 8'd140,
  parameter logic [7:0]  STEP       = 8'd2,
  parameter logic [19:0] MOVE_DIV   = 20'd250000,
  parameter logic [7:0]  HP_MAX     = 8'd100,
  parameter logic [23:0] INV_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] playerInstruction,
  input  logic        isMove,
  input  logic        startDmg,
  output logic [7:0]  player_x,
  output logic [7:0]  player_y,
  output logic [7:0]  hp,
  output logic        isDeath,
  output logic        dmg_ack,
  output logic        invuln
);

  typedef enum logic {ALIVE, DEAD} live_e;

  localparam logic [8:0] XS = {1'b0, X_MIN} + {1'b0, X_MAX};
  localparam logic [8:0] YS = {1'b0, Y_MIN} + {1'b0, Y_MAX};
  localparam logic [7:0] X_MID = XS[8:1];
  localparam logic [7:0] Y_MID = YS[8:1];

  live_e       state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d, hp_q, hp_d;
  logic        ack_q, ack_d, men_q, men_d;
  logic [19:0] cool_q, cool_d;
  logic [23:0] inv_q, inv_d;

  logic [3:0] op;
  logic [7:0] arg;
  logic       go;
  logic       is_hpy, is_dpy, is_idg, is_sdg, is_mov, is_shp;
  logic [8:0] sum9, up9, dn9, lf9, rt9;
  logic       unused_ok;

  assign op  = playerInstruction[15:12];
  assign arg = playerInstruction[11:4];
  assign go  = isMove | startDmg;
  assign unused_ok = ^playerInstruction[3:0];

  assign is_hpy = go && (op == 4'd1);
  assign is_dpy = go && (op == 4'd2);
  assign is_idg = go && (op == 4'd3);
  assign is_sdg = go && (op == 4'd4);
  assign is_mov = go && (op == 4'd5);
  assign is_shp = go && (op == 4'd6);

  // 9-bit intermediates so stepping past a bound saturates instead of wrapping
  assign sum9 = {1'b0, hp_q} + {1'b0, arg};
  assign up9  = {1'b0, y_q} - {1'b0, STEP};
  assign dn9  = {1'b0, y_q} + {1'b0, STEP};
  assign lf9  = {1'b0, x_q} - {1'b0, STEP};
  assign rt9  = {1'b0, x_q} + {1'b0, STEP};

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    hp_d    = hp_q;
    men_d   = men_q;
    ack_d   = 1'b0;
    state_d = state_q;
    cool_d  = (cool_q != '0) ? cool_q - 20'd1 : cool_q;
    inv_d   = (inv_q != '0) ? inv_q - 24'd1 : inv_q;

    unique case (1'b1)
      is_hpy: begin
        hp_d = (sum9 > {1'b0, HP_MAX}) ? HP_MAX : sum9[7:0];
      end
      is_dpy: begin
        if (inv_q == '0 && state_q == ALIVE) begin
          hp_d  = (arg >= hp_q) ? 8'd0 : hp_q - arg;
          ack_d = 1'b1;
          inv_d = INV_CYCLES;
        end
      end
      is_idg: begin
        x_d    = X_MID;
        y_d    = Y_MID;
        cool_d = '0;
        men_d  = 1'b1;
      end
      is_sdg: begin
        men_d = 1'b0;
      end
      is_mov: begin
        if (men_q && cool_q == '0 && state_q == ALIVE) begin
          cool_d = MOVE_DIV;
          unique case (arg[1:0])
            2'd0: y_d = (up9[8] || up9[7:0] < Y_MIN) ? Y_MIN : up9[7:0];
            2'd1: x_d = (lf9[8] || lf9[7:0] < X_MIN) ? X_MIN : lf9[7:0];
            2'd2: y_d = (dn9 > {1'b0, Y_MAX}) ? Y_MAX : dn9[7:0];
            2'd3: x_d = (rt9 > {1'b0, X_MAX}) ? X_MAX : rt9[7:0];
            default: ;
          endcase
        end
      end
      is_shp: begin
        hp_d  = (arg > HP_MAX) ? HP_MAX : arg;
        inv_d = '0;
      end
      default: ;
    endcase

    unique case (state_q)
      ALIVE: if (hp_d == 8'd0) state_d = DEAD;
      DEAD:  if ((is_hpy || is_shp) && hp_d != 8'd0) state_d = ALIVE;
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      x_q     <= X_MID;
      y_q     <= Y_MID;
      hp_q    <= HP_MAX;
      ack_q   <= 1'b0;
      men_q   <= 1'b1;
      cool_q  <= '0;
      inv_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hp_q    <= hp_d;
      ack_q   <= ack_d;
      men_q   <= men_d;
      cool_q  <= cool_d;
      inv_q   <= inv_d;
    end
  end

  assign player_x = x_q;
  assign player_y = y_q;
  assign hp       = hp_q;
  assign isDeath  = (state_q == DEAD);
  assign dmg_ack  = ack_q;
  assign invuln   = (inv_q != '0);

endmodule

// File: tb/tb_player_executor.sv
// Directed self-checking bench for player_executor with shortened
// cooldown/invulnerability windows and an odd Y_MAX for saturation.
module tb_player_executor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        isMove = 1'b0;
  logic        startDmg = 1'b0;
  logic [7:0]  player_x, player_y, hp;
  logic        isDeath, dmg_ack, invuln;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  player_executor #(
    .Y_MAX(8'd141),
    .MOVE_DIV(20'd4),
    .INV_CYCLES(24'd10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .playerInstruction(instr),
    .isMove(isMove),
    .startDmg(startDmg),
    .player_x(player_x),
    .player_y(player_y),
    .hp(hp),
    .isDeath(isDeath),
    .dmg_ack(dmg_ack),
    .invuln(invuln)
  );

  task automatic drive(input logic [3:0] op, input logic [7:0] a,
                       input logic mv, input logic dm);
    @(negedge clk);
    instr = {op, a, 4'h0};
    isMove = mv;
    startDmg = dm;
    @(posedge clk);
    #1;
    isMove = 1'b0;
    startDmg = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (player_x !== 8'd120) begin n_fail++; $display("FAIL rst_x got %0d want 120", player_x); end
    n_chk++; if (player_y !== 8'd80) begin n_fail++; $display("FAIL rst_y got %0d want 80", player_y); end
    n_chk++; if (hp !== 8'd100) begin n_fail++; $display("FAIL rst_hp got %0d want 100", hp); end
    n_chk++; if ({isDeath, dmg_ack, invuln} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {isDeath, dmg_ack, invuln}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_move_rate;
    logic [7:0] exp [12] = '{8'd122, 8'd122, 8'd122, 8'd122, 8'd122, 8'd124,
                             8'd124, 8'd124, 8'd124, 8'd124, 8'd126, 8'd126};
    @(negedge clk);
    instr = {4'd5, 8'd3, 4'h0};
    isMove = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (player_x !== exp[i]) begin
        n_fail++;
        $display("FAIL move_rate edge %0d got %0d want %0d", i + 1, player_x, exp[i]);
      end
    end
    isMove = 1'b0;
    idle(6);
  endtask

  task automatic test_saturate;
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'hff;
    @(negedge clk);
    instr = {4'd5, 8'd1, 4'h0};
    isMove = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (player_x < lo) lo = player_x;
    end
    isMove = 1'b0;
    n_chk++; if (player_x !== 8'd20) begin n_fail++; $display("FAIL sat_left got %0d want 20", player_x); end
    n_chk++; if (lo !== 8'd20) begin n_fail++; $display("FAIL sat_left_min got %0d want 20", lo); end
    hi = 8'h00;
    @(negedge clk);
    instr = {4'd5, 8'd2, 4'h0};
    isMove = 1'b1;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (player_y > hi) hi = player_y;
    end
    isMove = 1'b0;
    n_chk++; if (player_y !== 8'd141) begin n_fail++; $display("FAIL sat_down got %0d want 141", player_y); end
    n_chk++; if (hi !== 8'd141) begin n_fail++; $display("FAIL sat_down_max got %0d want 141", hi); end
    idle(6);
  endtask

  task automatic test_damage;
    int n;
    drive(4'd2, 8'd30, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd70) begin n_fail++; $display("FAIL dpy1_hp got %0d want 70", hp); end
    n_chk++; if ({dmg_ack, invuln} !== 2'b11) begin n_fail++; $display("FAIL dpy1_flags got %b want 11", {dmg_ack, invuln}); end
    idle(1);
    n_chk++; if (dmg_ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse got %b want 0", dmg_ack); end
    drive(4'd2, 8'd30, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd70) begin n_fail++; $display("FAIL dpy_inv_hp got %0d want 70", hp); end
    n_chk++; if ({dmg_ack, invuln} !== 2'b01) begin n_fail++; $display("FAIL dpy_inv_flags got %b want 01", {dmg_ack, invuln}); end
    n = 0;
    while (invuln === 1'b1 && n < 50) begin idle(1); n++; end
    n_chk++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL inv_expire got %b want 0", invuln); end
    drive(4'd2, 8'd30, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd40) begin n_fail++; $display("FAIL dpy2_hp got %0d want 40", hp); end
    n_chk++; if (dmg_ack !== 1'b1) begin n_fail++; $display("FAIL dpy2_ack got %b want 1", dmg_ack); end
    n = 0;
    while (invuln === 1'b1 && n < 50) begin idle(1); n++; end
    n_chk++; if (n !== 10) begin n_fail++; $display("FAIL inv_len got %0d want 10", n); end
  endtask

  task automatic test_death;
    drive(4'd2, 8'd200, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd0) begin n_fail++; $display("FAIL kill_hp got %0d want 0", hp); end
    n_chk++; if (isDeath !== 1'b1) begin n_fail++; $display("FAIL kill_death got %b want 1", isDeath); end
    drive(4'd5, 8'd3, 1'b1, 1'b0);
    n_chk++; if (player_x !== 8'd20) begin n_fail++; $display("FAIL dead_mov got %0d want 20", player_x); end
    drive(4'd1, 8'd10, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd10) begin n_fail++; $display("FAIL revive_hp got %0d want 10", hp); end
    n_chk++; if (isDeath !== 1'b0) begin n_fail++; $display("FAIL revive_death got %b want 0", isDeath); end
  endtask

  task automatic test_heal;
    drive(4'd6, 8'd90, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd90) begin n_fail++; $display("FAIL shp90 got %0d want 90", hp); end
    n_chk++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL shp_inv got %b want 0", invuln); end
    drive(4'd1, 8'd50, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd100) begin n_fail++; $display("FAIL hpy_cap got %0d want 100", hp); end
    drive(4'd6, 8'd255, 1'b0, 1'b1);
    n_chk++; if (hp !== 8'd100) begin n_fail++; $display("FAIL shp_cap got %0d want 100", hp); end
    drive(4'd6, 8'd0, 1'b0, 1'b1);
    n_chk++; if ({hp, isDeath} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL shp0 got hp %0d death %b want 0 1", hp, isDeath); end
    drive(4'd6, 8'd100, 1'b0, 1'b1);
    n_chk++; if ({hp, isDeath} !== {8'd100, 1'b0}) begin n_fail++; $display("FAIL shp100 got hp %0d death %b want 100 0", hp, isDeath); end
  endtask

  task automatic test_sdg_idg;
    drive(4'd4, 8'd0, 1'b1, 1'b0);
    drive(4'd5, 8'd3, 1'b1, 1'b0);
    n_chk++; if (player_x !== 8'd20) begin n_fail++; $display("FAIL sdg_frozen got %0d want 20", player_x); end
    drive(4'd3, 8'd0, 1'b1, 1'b0);
    n_chk++; if ({player_x, player_y} !== {8'd120, 8'd80}) begin n_fail++; $display("FAIL idg_center got %0d,%0d want 120,80", player_x, player_y); end
    drive(4'd5, 8'd3, 1'b1, 1'b1);
    n_chk++; if (player_x !== 8'd122) begin n_fail++; $display("FAIL idg_mov got %0d want 122", player_x); end
    idle(2);
    n_chk++; if (player_x !== 8'd122) begin n_fail++; $display("FAIL dual_strobe got %0d want 122", player_x); end
  endtask

  task automatic test_reset_mid;
    drive(4'd2, 8'd10, 1'b0, 1'b1);
    n_chk++; if ({hp, invuln} !== {8'd90, 1'b1}) begin n_fail++; $display("FAIL pre_rst got hp %0d inv %b want 90 1", hp, invuln); end
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({player_x, player_y} !== {8'd120, 8'd80}) begin n_fail++; $display("FAIL arst_pos got %0d,%0d want 120,80", player_x, player_y); end
    n_chk++; if ({hp, isDeath, dmg_ack, invuln} !== {8'd100, 3'b000}) begin n_fail++; $display("FAIL arst_state got hp %0d flags %b want 100 000", hp, {isDeath, dmg_ack, invuln}); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    n_chk++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL post_rst_inv got %b want 0", invuln); end
    drive(4'd5, 8'd3, 1'b1, 1'b0);
    n_chk++; if (player_x !== 8'd122) begin n_fail++; $display("FAIL post_rst_mov got %0d want 122", player_x); end
  endtask

  initial begin
    test_reset();
    test_move_rate();
    test_saturate();
    test_damage();
    test_death();
    test_heal();
    test_sdg_idg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
